// File: rtl/ripple_carry_adder_pkg.sv
// ripple_carry_adder_pkg
//   Shared constants for the registered ripple-carry add/subtract unit.
//   DEFAULT_WIDTH    : operand/result width used when the top is not overridden
//   RESULT_RESET_BIT : value every result bit and flag takes while reset is held
package ripple_carry_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Results clear to all zeros; the top replicates this bit across each bus.
  localparam logic RESULT_RESET_BIT = 1'b0;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// full_adder
//   One-bit full adder cell, the building block of both ripple chains.
//   a, b : operand bits
//   cin  : carry in from the previous stage
//   s    : sum bit (a ^ b ^ cin)
//   cout : carry to the next stage (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//   Registered add/subtract unit for the ALU add and subtract paths.
//   Every cycle it computes A+B+Cin and A-B through two independent
//   ripple-carry chains and registers the results with one cycle latency.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-low; clears all outputs
//   A, B   : operands (A is the minuend, B the subtrahend)
//   Cin    : carry-in of the addition chain only
//   Sum    : (A + B + Cin) mod 2^WIDTH
//   Cout   : carry out of the addition MSB
//   Diff   : (A - B) mod 2^WIDTH
//   Borrow : 1 when A < B unsigned
//   AddOvf : signed overflow of the addition
//   SubOvf : signed overflow of the subtraction
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             AddOvf,
  output logic             SubOvf
);

  logic [WIDTH:0]   add_c;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH:0]   sub_c;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] b_inv;

  logic add_ovf;
  logic sub_ovf;
  logic borrow;

  // Subtraction is A + ~B + 1: the +1 enters as the chain's carry-in.
  assign b_inv    = ~B;
  assign add_c[0] = Cin;
  assign sub_c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_add (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (add_c[i]),
      .s    (add_s[i]),
      .cout (add_c[i+1])
    );

    full_adder u_sub (
      .a    (A[i]),
      .b    (b_inv[i]),
      .cin  (sub_c[i]),
      .s    (sub_s[i]),
      .cout (sub_c[i+1])
    );
  end

  // Signed overflow shows up as disagreement between the carries into and
  // out of the sign bit. A carry out of the subtract chain means no borrow.
  assign add_ovf = add_c[WIDTH] ^ add_c[WIDTH-1];
  assign sub_ovf = sub_c[WIDTH] ^ sub_c[WIDTH-1];
  assign borrow  = ~sub_c[WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      Sum    <= {WIDTH{RESULT_RESET_BIT}};
      Cout   <= RESULT_RESET_BIT;
      Diff   <= {WIDTH{RESULT_RESET_BIT}};
      Borrow <= RESULT_RESET_BIT;
      AddOvf <= RESULT_RESET_BIT;
      SubOvf <= RESULT_RESET_BIT;
    end else begin
      Sum    <= add_s;
      Cout   <= add_c[WIDTH];
      Diff   <= sub_s;
      Borrow <= borrow;
      AddOvf <= add_ovf;
      SubOvf <= sub_ovf;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder
//   Directed and random stimulus for ripple_carry_adder. Expected results are
//   pushed into a queue when operands are driven and popped one cycle later.
module tb_ripple_carry_adder;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] diff;
    logic         borrow;
    logic         addOvf;
    logic         subOvf;
    string        tag;
  } expect_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] Sum;
  logic         Cout;
  logic [W-1:0] Diff;
  logic         Borrow;
  logic         AddOvf;
  logic         SubOvf;

  expect_t scoreboard[$];
  int checks = 0;
  int errors = 0;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Diff   (Diff),
    .Borrow (Borrow),
    .AddOvf (AddOvf),
    .SubOvf (SubOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model built on wide integer arithmetic and sign comparisons.
  function automatic expect_t modelOf(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic rst, input string tag);
    expect_t e;
    logic [W:0] wide;
    logic [W-1:0] d;
    e.tag = tag;
    if (!rst) begin
      e.sum = '0; e.cout = 1'b0; e.diff = '0;
      e.borrow = 1'b0; e.addOvf = 1'b0; e.subOvf = 1'b0;
    end else begin
      wide     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      d        = a - b;
      e.sum    = wide[W-1:0];
      e.cout   = wide[W];
      e.diff   = d;
      e.borrow = (a < b);
      e.addOvf = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
      e.subOvf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic rst, input string tag);
    @(negedge clk);
    A = a; B = b; Cin = cin; reset = rst;
    scoreboard.push_back(modelOf(a, b, cin, rst, tag));
  endtask

  task automatic applyDirected(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] eSum, input logic eCout,
                               input logic [W-1:0] eDiff, input logic eBorrow,
                               input logic eAddOvf, input logic eSubOvf, input string tag);
    expect_t e;
    @(negedge clk);
    A = a; B = b; Cin = cin; reset = 1'b1;
    e.sum = eSum; e.cout = eCout; e.diff = eDiff; e.borrow = eBorrow;
    e.addOvf = eAddOvf; e.subOvf = eSubOvf; e.tag = tag;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    expect_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (scoreboard.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
      checks++;
      assert (Sum === e.sum) else begin
        errors++;
        $error("[TB] FAIL %s Sum: observed %h expected %h", e.tag, Sum, e.sum);
      end
      checks++;
      assert (Cout === e.cout) else begin
        errors++;
        $error("[TB] FAIL %s Cout: observed %b expected %b", e.tag, Cout, e.cout);
      end
      checks++;
      assert (Diff === e.diff) else begin
        errors++;
        $error("[TB] FAIL %s Diff: observed %h expected %h", e.tag, Diff, e.diff);
      end
      checks++;
      assert (Borrow === e.borrow) else begin
        errors++;
        $error("[TB] FAIL %s Borrow: observed %b expected %b", e.tag, Borrow, e.borrow);
      end
      checks++;
      assert (AddOvf === e.addOvf) else begin
        errors++;
        $error("[TB] FAIL %s AddOvf: observed %b expected %b", e.tag, AddOvf, e.addOvf);
      end
      checks++;
      assert (SubOvf === e.subOvf) else begin
        errors++;
        $error("[TB] FAIL %s SubOvf: observed %b expected %b", e.tag, SubOvf, e.subOvf);
      end
    end
  endtask

  initial begin
    A = '0; B = '0; Cin = 1'b0; reset = 1'b0;

    // Reset with nonzero operands, then release with the same operands.
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "reset_hold");
    checkOutput();
    applyDirected(32'hFFFF_FFFF, 32'h1, 1'b0,
                  32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "reset_release");
    checkOutput();

    applyDirected(32'd5, 32'd7, 1'b0,
                  32'd12, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, "unsigned_borrow");
    checkOutput();
    applyDirected(32'h1234_5678, 32'h1234_5678, 1'b1,
                  32'h2468_ACF1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "equal_cin");
    checkOutput();
    applyDirected(32'h0, 32'hFFFF_FFFF, 1'b1,
                  32'h0, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, "carry_through");
    checkOutput();
    applyDirected(32'h7FFF_FFFF, 32'h1, 1'b0,
                  32'h8000_0000, 1'b0, 32'h7FFF_FFFE, 1'b0, 1'b1, 1'b0, "add_overflow");
    checkOutput();
    applyDirected(32'h8000_0000, 32'h1, 1'b0,
                  32'h8000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, "sub_overflow");
    checkOutput();
    applyDirected(32'hDEAD_BEEF, 32'h0, 1'b1,
                  32'hDEAD_BEF0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "b_zero");
    checkOutput();

    // Back-to-back random operands, one per cycle.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, "random");
      checkOutput();
    end

    // Reset for a single cycle between two operations.
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "pre_reset");
    checkOutput();
    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, "mid_reset");
    checkOutput();
    applyStimulus(32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 1'b1, "post_reset");
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
